// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: one read/write request at a time,
// serviced from a little-endian byte array LATENCY edges after acceptance.
module data_memory_responder #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [1:0]  num_bytes,
  input  logic [15:0] address,
  input  logic [15:0] wr_data,
  output logic        resp_valid,
  output logic [15:0] rd_data,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW        = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int unsigned CW        = 4;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
  localparam logic [16:0]   DEPTH_LIM = 17'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept_c, commit_c;

  logic            q_rd, q_wr;
  logic [1:0]      q_nb;
  logic [15:0]     q_addr, q_wdata;

  logic            half_c, err_c;
  logic [16:0]     last_addr_c;
  logic [AW-1:0]   idx0_c, idx1_c;
  logic [15:0]     rd_val_c;

  logic [7:0]      mem [DEPTH_BYTES];

  // Legality check and read-data assembly for the latched request
  always_comb begin
    half_c      = (q_nb == 2'b10);
    last_addr_c = {1'b0, q_addr} + 17'(half_c);
    err_c       = (q_rd & q_wr) | (q_nb == 2'b00) | (q_nb == 2'b11) |
                  (half_c & q_addr[0]) | (last_addr_c >= DEPTH_LIM);
    idx0_c      = q_addr[AW-1:0];
    idx1_c      = idx0_c + AW'(1);
    rd_val_c    = 16'h0000;
    if (!err_c && q_rd) begin
      rd_val_c = half_c ? {mem[idx1_c], mem[idx0_c]} : {8'h00, mem[idx0_c]};
    end
  end

  // Next-state: IDLE -> WAIT (LATENCY-1 countdown) -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && (rd_en || wr_en)) begin
          accept_c  = 1'b1;
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    commit_c = (state_nxt == S_RESP);
  end

  // State register and registered response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_data    <= 16'h0000;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= (state_nxt == S_IDLE);
      busy       <= (state_nxt != S_IDLE);
      resp_valid <= commit_c;
      resp_err   <= commit_c & err_c;
      if (commit_c) begin
        rd_data <= rd_val_c;
      end
    end
  end

  // Capture the request fields at the accept edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_rd    <= 1'b0;
      q_wr    <= 1'b0;
      q_nb    <= 2'b00;
      q_addr  <= 16'h0000;
      q_wdata <= 16'h0000;
    end else if (accept_c) begin
      q_rd    <= rd_en;
      q_wr    <= wr_en;
      q_nb    <= num_bytes;
      q_addr  <= address;
      q_wdata <= wr_data;
    end
  end

  // Storage update on the commit edge; reset drops an in-flight write
  always_ff @(posedge clk) begin
    if (reset && commit_c && q_wr && !err_c) begin
      mem[idx0_c] <= q_wdata[7:0];
      if (half_c) begin
        mem[idx1_c] <= q_wdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (LATENCY 1, 2, 4) share
// stimulus; each is compared every cycle against a transaction-level model.
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, rd_en, wr_en;
  logic [1:0]  num_bytes;
  logic [15:0] address, wr_data;

  logic [2:0]       rr, rv, re, bz;
  logic [2:0][15:0] rdd;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .DEPTH_BYTES(256),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr[g]),
      .rd_en(rd_en), .wr_en(wr_en), .num_bytes(num_bytes), .address(address),
      .wr_data(wr_data), .resp_valid(rv[g]), .rd_data(rdd[g]),
      .resp_err(re[g]), .busy(bz[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: edges remaining until idle, latched request, byte store
  int          rem [3];
  logic        mv [3], me [3];
  logic [15:0] mrd [3];
  logic [7:0]  mm [3][256];
  logic        qrd [3], qwr [3];
  logic [1:0]  qnb [3];
  logic [15:0] qa [3], qw [3];
  int          acc_cnt [3], rsp_cnt [3];

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  nb;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl [18];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d (LATENCY=%0d) t=%0t: got %h, want %h", nm, d, lat_of(d), $time, act, exp);
    end
  endtask

  task automatic resolve(input int d);
    int a, n;
    bit bad;
    a = int'(qa[d]);
    n = (qnb[d] == 2'b01) ? 1 : ((qnb[d] == 2'b10) ? 2 : 0);
    bad = (qrd[d] && qwr[d]) || (n == 0) || (n == 2 && (a % 2) == 1) || (a + n > 256);
    if (bad) begin
      me[d]  = 1'b1;
      mrd[d] = 16'h0000;
    end else if (qwr[d]) begin
      mm[d][a] = qw[d][7:0];
      if (n == 2) mm[d][a+1] = qw[d][15:8];
      mrd[d] = 16'h0000;
    end else begin
      mrd[d] = (n == 1) ? {8'h00, mm[d][a]} : {mm[d][a+1], mm[d][a]};
    end
  endtask

  task automatic model_edge(input int d);
    if (!reset) begin
      rem[d] = 0; mv[d] = 1'b0; me[d] = 1'b0; mrd[d] = 16'h0000;
    end else if (rem[d] != 0) begin
      rem[d]--;
      mv[d] = 1'b0; me[d] = 1'b0;
      if (rem[d] == 1) begin
        mv[d] = 1'b1;
        resolve(d);
      end
    end else begin
      mv[d] = 1'b0; me[d] = 1'b0;
      if (req_valid && (rd_en || wr_en)) begin
        qrd[d] = rd_en; qwr[d] = wr_en; qnb[d] = num_bytes;
        qa[d] = address; qw[d] = wr_data;
        rem[d] = lat_of(d) + 1;
        acc_cnt[d]++;
      end
    end
  endtask

  // One clock: advance model at the edge, compare every output 1 time unit later
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("req_ready",  d, 16'(rr[d]), 16'(rem[d] == 0));
      chk("busy",       d, 16'(bz[d]), 16'(rem[d] != 0));
      chk("resp_valid", d, 16'(rv[d]), 16'(mv[d]));
      chk("resp_err",   d, 16'(re[d]), 16'(me[d]));
      chk("rd_data",    d, rdd[d], mrd[d]);
      if (rv[d]) rsp_cnt[d]++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((rem[0] != 0 || rem[1] != 0 || rem[2] != 0) && k < 20) begin
      step();
      k++;
    end
    for (int d = 0; d < 3; d++) chk("idle_before_req", d, 16'(bz[d]), 16'h0000);
  endtask

  // Single request to all instances; returns the LATENCY=2 instance's response
  task automatic do_req(input logic r, input logic w, input logic [1:0] nb,
                        input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] got, output logic gerr);
    int first [3];
    got = 16'h0000;
    gerr = 1'b0;
    wait_idle();
    req_valid = 1'b1; rd_en = r; wr_en = w; num_bytes = nb; address = a; wr_data = wd;
    step();
    req_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    first = '{-1, -1, -1};
    for (int k = 1; k <= 8; k++) begin
      step();
      for (int d = 0; d < 3; d++) if (rv[d] && first[d] < 0) first[d] = k;
      if (rv[1]) begin
        got = rdd[1];
        gerr = re[1];
      end
      if (first[0] >= 0 && first[1] >= 0 && first[2] >= 0) break;
    end
    for (int d = 0; d < 3; d++) chk("resp_latency", d, 16'(first[d]), 16'(lat_of(d)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got, prev;
    logic        gerr;

    tbl[0]  = '{1'b0, 1'b1, 2'b10, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'b10, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b01, 16'h0010, 16'h0000, 16'h00EF, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 16'h0011, 16'h0000, 16'h00BE, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'b01, 16'h0011, 16'h1234, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'b10, 16'h0010, 16'h0000, 16'h34EF, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'b10, 16'h0011, 16'h0000, 16'h0000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'h0000, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 2'b10, 16'h0010, 16'hFFFF, 16'h0000, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'b10, 16'h00FF, 16'h0000, 16'h0000, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 2'b01, 16'h0100, 16'h0000, 16'h0000, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'b10, 16'h0010, 16'h0000, 16'h34EF, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'b10, 16'h00FE, 16'h1357, 16'h0000, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'b10, 16'h00FE, 16'h0000, 16'h1357, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 2'b01, 16'h00FF, 16'h0000, 16'h0013, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'h0000, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 2'b01, 16'h0100, 16'h00AA, 16'h0000, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 2'b10, 16'h0010, 16'h0000, 16'h34EF, 1'b0};

    for (int d = 0; d < 3; d++) begin
      rem[d] = 0; mv[d] = 1'b0; me[d] = 1'b0; mrd[d] = 16'h0000;
      acc_cnt[d] = 0; rsp_cnt[d] = 0;
    end

    // Reset with a request pending: reset must win
    reset = 1'b0; req_valid = 1'b1; rd_en = 1'b1; wr_en = 1'b0;
    num_bytes = 2'b10; address = 16'h0000; wr_data = 16'h0000;
    step();
    step();
    req_valid = 1'b0; rd_en = 1'b0;
    reset = 1'b1;
    step();

    // Fill storage so every later read has a known expected value
    for (int a = 0; a < 256; a += 2) begin
      do_req(1'b0, 1'b1, 2'b10, 16'(a), 16'($urandom), got, gerr);
    end

    // Directed table: write/read, byte lanes, partial write, illegal requests
    for (int i = 0; i < 18; i++) begin
      do_req(tbl[i].r, tbl[i].w, tbl[i].nb, tbl[i].a, tbl[i].wd, got, gerr);
      chk($sformatf("tbl%0d_rd_data", i), 1, got, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_resp_err", i), 1, 16'(gerr), 16'(tbl[i].exp_err));
    end

    // req_valid held high with alternating requests, then with no operation
    wait_idle();
    for (int d = 0; d < 3; d++) begin acc_cnt[d] = 0; rsp_cnt[d] = 0; end
    for (int c = 0; c < 48; c++) begin
      req_valid = 1'b1;
      num_bytes = (c % 2 == 0) ? 2'b10 : 2'b01;
      address   = (c % 2 == 0) ? 16'h0010 : 16'h0031;
      wr_data   = 16'(c * 16'h0111);
      rd_en     = (c < 36) && (c % 2 == 0);
      wr_en     = (c < 36) && (c % 2 == 1);
      step();
    end
    req_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 8; c++) step();
    for (int d = 0; d < 3; d++) chk("accepts_vs_responses", d, 16'(rsp_cnt[d]), 16'(acc_cnt[d]));

    // Reset one cycle after accepting a write: write is dropped
    wait_idle();
    prev = {mm[1][8'h21], mm[1][8'h20]};
    req_valid = 1'b1; rd_en = 1'b0; wr_en = 1'b1; num_bytes = 2'b10;
    address = 16'h0020; wr_data = 16'hA5A5;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    do_req(1'b1, 1'b0, 2'b10, 16'h0020, 16'h0000, got, gerr);
    chk("reset_drops_write", 1, got, prev);

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      int sel;
      req_valid = ($urandom_range(0, 3) != 0);
      rd_en     = 1'($urandom_range(0, 1));
      wr_en     = 1'($urandom_range(0, 1));
      sel       = int'($urandom_range(0, 9));
      num_bytes = (sel < 4) ? 2'b01 : ((sel < 8) ? 2'b10 : ((sel == 8) ? 2'b00 : 2'b11));
      address   = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 257));
      wr_data   = 16'($urandom);
      reset     = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1; req_valid = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 8; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
